// File: rtl/serial_addsub_if.sv
// Handshake and data bundle for serial_addsub: operands and start flow in,
// status and registered result flow out.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: BPC-bit ripple slice plus carry flip-flop,
// WIDTH/BPC RUN cycles, result/carry/overflow registered on completion.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic          clk,
  input  logic          rst,
  serial_addsub_if.slave bus
);

  localparam int STEPS = WIDTH / BPC;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and divisible by BPC");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [BPC-1:0]     slice_sum;
  logic               slice_cout;
  logic               slice_cmsb;
  logic               rc;
  logic [WIDTH-1:0]   res_shift;

  // Ripple slice over the low BPC bits; slice_cmsb is the carry into the
  // slice's top bit, which is bit WIDTH-1 on the final step.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise synthesis infers a latch for the paths that skip it.
    slice_sum  = '0;
    slice_cmsb = carry_q;
    rc         = carry_q;
    for (int i = 0; i < BPC; i++) begin
      slice_cmsb   = rc;
      slice_sum[i] = opa_q[i] ^ opb_q[i] ^ rc;
      rc           = (opa_q[i] & opb_q[i]) | (rc & (opa_q[i] ^ opb_q[i]));
    end
    slice_cout = rc;
  end

  assign res_shift = (res_q >> BPC) | (WIDTH'(slice_sum) << (WIDTH - BPC));

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          opa_d   = bus.a;
          opb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.cin ^ bus.sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        opa_d   = opa_q >> BPC;
        opb_d   = opb_q >> BPC;
        res_d   = res_shift;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          sum_d   = res_shift;
          cout_d  = slice_cout;
          ovf_d   = slice_cmsb ^ slice_cout;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
